// File: rtl/kernel_dispatcher.sv
// Purpose : kernel-launch front end; holds the thread-count DCR, splits the kernel into blocks, and dispatches them across NUM_CORES cores.
// Latency : start at edge E0 enters DISPATCH; block k (all cores free) starts after edge E1+k; done rises on the edge that retires the last block.
// Backpressure: at most one block assigned per edge, only to a free core; start and DCR writes are ignored while dispatching.
//
// Ports:
//   clk, reset (async, active-low)
//   start                        launch request, honoured in IDLE/DONE
//   device_control_write_enable  DCR write strobe, data on device_control_data
//   core_done[i]                 level, block on core i complete (ignored when core idle)
//   core_start[i]                high while core i holds a block
//   core_block_id / core_thread_count   per-core block id and active thread count
//   busy                         high in DISPATCH
//   done                         sticky kernel-complete flag
module kernel_dispatcher #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int DCR_WIDTH         = 8,
    parameter int BLOCK_ID_WIDTH    = 8,
    parameter int TCW               = $clog2(THREADS_PER_BLOCK + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                device_control_write_enable,
    input  logic [DCR_WIDTH-1:0]                device_control_data,
    input  logic [NUM_CORES-1:0]                core_done,
    output logic [NUM_CORES-1:0]                core_start,
    output logic [NUM_CORES*BLOCK_ID_WIDTH-1:0] core_block_id,
    output logic [NUM_CORES*TCW-1:0]            core_thread_count,
    output logic                                busy,
    output logic                                done
);

    localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);
    localparam logic [DCR_WIDTH-1:0] TPB_MASK = DCR_WIDTH'(THREADS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    state_t               state;
    logic [DCR_WIDTH-1:0] dcr;
    logic [DCR_WIDTH-1:0] total_blocks;
    logic [DCR_WIDTH-1:0] blocks_dispatched;
    logic [DCR_WIDTH-1:0] blocks_done;

    logic [DCR_WIDTH-1:0] ceil_blocks;
    logic [DCR_WIDTH-1:0] last_count;
    logic [NUM_CORES-1:0] retire_mask;
    logic [NUM_CORES-1:0] assign_mask;
    logic                 assign_vld;
    logic [DCR_WIDTH-1:0] retire_count;
    logic [DCR_WIDTH-1:0] done_next;
    logic [TCW-1:0]       block_count;

    // ceil(dcr / TPB) without an intermediate add, so dcr at full scale cannot overflow
    assign ceil_blocks = (dcr >> LOG2_TPB) + DCR_WIDTH'((dcr & TPB_MASK) != '0);
    assign last_count  = dcr - ((total_blocks - DCR_WIDTH'(1)) << LOG2_TPB);

    assign retire_mask = core_start & core_done;
    // Lowest clear bit of core_start: cores retiring this edge still read as busy here
    assign assign_mask = ~core_start & (core_start + NUM_CORES'(1));
    assign assign_vld  = (|assign_mask) && (blocks_dispatched < total_blocks);
    assign block_count = (blocks_dispatched == total_blocks - DCR_WIDTH'(1))
                       ? TCW'(last_count) : TCW'(THREADS_PER_BLOCK);

    always_comb begin
        retire_count = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (retire_mask[i]) retire_count = retire_count + DCR_WIDTH'(1);
        end
        done_next = blocks_done + retire_count;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= ST_IDLE;
            dcr               <= '0;
            total_blocks      <= '0;
            blocks_dispatched <= '0;
            blocks_done       <= '0;
            core_start        <= '0;
            core_block_id     <= '0;
            core_thread_count <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            if (device_control_write_enable && state != ST_DISPATCH) begin
                dcr <= device_control_data;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        done              <= 1'b0;
                        total_blocks      <= ceil_blocks;
                        blocks_dispatched <= '0;
                        blocks_done       <= '0;
                        if (dcr == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_DISPATCH;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_DISPATCH: begin
                    core_start  <= (core_start & ~retire_mask) | (assign_vld ? assign_mask : '0);
                    blocks_done <= done_next;
                    if (assign_vld) begin
                        blocks_dispatched <= blocks_dispatched + DCR_WIDTH'(1);
                        for (int i = 0; i < NUM_CORES; i++) begin
                            if (assign_mask[i]) begin
                                core_block_id[i*BLOCK_ID_WIDTH +: BLOCK_ID_WIDTH] <= BLOCK_ID_WIDTH'(blocks_dispatched);
                                core_thread_count[i*TCW +: TCW]                   <= block_count;
                            end
                        end
                    end
                    // No block can be outstanding here, so no assignment collides with completion
                    if (done_next == total_blocks) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_dispatcher.sv
// Purpose : directed self-checking bench for kernel_dispatcher (2 cores, 4 threads/block).
// Latency : inputs driven and outputs sampled 1 ns after each rising edge.
// Backpressure: core_done driven directly by the bench per step.
module tb_kernel_dispatcher;

    localparam int NC  = 2;
    localparam int TPB = 4;
    localparam int DW  = 8;
    localparam int BW  = 8;
    localparam int TCW = 3;

    logic                clk;
    logic                reset;
    logic                start;
    logic                device_control_write_enable;
    logic [DW-1:0]       device_control_data;
    logic [NC-1:0]       core_done;
    logic [NC-1:0]       core_start;
    logic [NC*BW-1:0]    core_block_id;
    logic [NC*TCW-1:0]   core_thread_count;
    logic                busy;
    logic                done;

    int errors = 0;
    int checks = 0;

    kernel_dispatcher #(
        .NUM_CORES(NC), .THREADS_PER_BLOCK(TPB), .DCR_WIDTH(DW), .BLOCK_ID_WIDTH(BW)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .start                       (start),
        .device_control_write_enable (device_control_write_enable),
        .device_control_data         (device_control_data),
        .core_done                   (core_done),
        .core_start                  (core_start),
        .core_block_id               (core_block_id),
        .core_thread_count           (core_thread_count),
        .busy                        (busy),
        .done                        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_dcr(input logic [DW-1:0] v);
        device_control_write_enable = 1'b1;
        device_control_data         = v;
        step();
        device_control_write_enable = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [BW-1:0] bid(input int i);
        return core_block_id[i*BW +: BW];
    endfunction

    function automatic logic [TCW-1:0] tcnt(input int i);
        return core_thread_count[i*TCW +: TCW];
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        device_control_write_enable = 1'b0;
        device_control_data = '0;
        core_done = '0;
        #1 reset = 1'b0;
        step();
        step();
        chk("rst_core_start", 32'(core_start), 32'h0);
        chk("rst_block_id", 32'(core_block_id), 32'h0);
        chk("rst_thread_cnt", 32'(core_thread_count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        reset = 1'b1;
        step();

        // 1: single block of 4 threads on core 0
        write_dcr(8'd4);
        pulse_start();
        chk("t1_busy_e0", 32'(busy), 32'h1);
        chk("t1_cs_e0", 32'(core_start), 32'h0);
        step();
        chk("t1_cs_e1", 32'(core_start), 32'h1);
        chk("t1_id0", 32'(bid(0)), 32'h0);
        chk("t1_tc0", 32'(tcnt(0)), 32'h4);
        for (int k = 0; k < 4; k++) step();
        chk("t1_cs_wait", 32'(core_start), 32'h1);
        chk("t1_done_wait", 32'(done), 32'h0);
        core_done = 2'b01;
        step();
        core_done = 2'b00;
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_busy_end", 32'(busy), 32'h0);
        chk("t1_cs_end", 32'(core_start), 32'h0);
        chk("t1_tc0_hold", 32'(tcnt(0)), 32'h4);

        // 2: ten threads -> blocks of 4,4,2; core_done ignored on an idle core
        write_dcr(8'd10);
        pulse_start();
        chk("t2_done_clr", 32'(done), 32'h0);
        step();
        chk("t2_cs_e1", 32'(core_start), 32'h1);
        chk("t2_id0_e1", 32'(bid(0)), 32'h0);
        chk("t2_tc0_e1", 32'(tcnt(0)), 32'h4);
        step();
        chk("t2_cs_e2", 32'(core_start), 32'h3);
        chk("t2_id1_e2", 32'(bid(1)), 32'h1);
        chk("t2_tc1_e2", 32'(tcnt(1)), 32'h4);
        step();
        core_done = 2'b01;
        step();
        core_done = 2'b00;
        chk("t2_cs_retire0", 32'(core_start), 32'h2);
        chk("t2_done_mid", 32'(done), 32'h0);
        step();
        chk("t2_cs_blk2", 32'(core_start), 32'h3);
        chk("t2_id0_blk2", 32'(bid(0)), 32'h2);
        chk("t2_tc0_blk2", 32'(tcnt(0)), 32'h2);
        core_done = 2'b10;
        step();
        chk("t2_cs_retire1", 32'(core_start), 32'h1);
        chk("t2_done_mid2", 32'(done), 32'h0);
        step();
        chk("t2_cs_ignore", 32'(core_start), 32'h1);
        chk("t2_done_ignore", 32'(done), 32'h0);
        core_done = 2'b01;
        step();
        core_done = 2'b00;
        chk("t2_done", 32'(done), 32'h1);
        chk("t2_busy_end", 32'(busy), 32'h0);

        // 3: zero-thread kernel completes at the start edge
        write_dcr(8'd0);
        pulse_start();
        chk("t3_done", 32'(done), 32'h1);
        chk("t3_busy", 32'(busy), 32'h0);
        chk("t3_cs", 32'(core_start), 32'h0);
        step();
        step();
        chk("t3_cs_later", 32'(core_start), 32'h0);
        chk("t3_done_sticky", 32'(done), 32'h1);

        // 4: DCR write and start during DISPATCH are ignored (DCR=6 -> blocks 4,2)
        write_dcr(8'd6);
        pulse_start();
        write_dcr(8'd99);
        chk("t4_cs_e1", 32'(core_start), 32'h1);
        pulse_start();
        chk("t4_cs_e2", 32'(core_start), 32'h3);
        chk("t4_id1", 32'(bid(1)), 32'h1);
        chk("t4_tc1", 32'(tcnt(1)), 32'h2);
        step();
        chk("t4_cs_hold", 32'(core_start), 32'h3);
        chk("t4_busy_hold", 32'(busy), 32'h1);
        core_done = 2'b11;
        step();
        core_done = 2'b00;
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_cs_end", 32'(core_start), 32'h0);
        pulse_start();
        step();
        chk("t4r_tc0", 32'(tcnt(0)), 32'h4);
        step();
        chk("t4r_cs", 32'(core_start), 32'h3);
        chk("t4r_tc1", 32'(tcnt(1)), 32'h2);
        core_done = 2'b11;
        step();
        core_done = 2'b00;
        chk("t4r_done", 32'(done), 32'h1);

        // 5: simultaneous completion of both blocks
        write_dcr(8'd8);
        pulse_start();
        step();
        step();
        chk("t5_cs", 32'(core_start), 32'h3);
        chk("t5_tc", 32'(core_thread_count), 32'({3'd4, 3'd4}));
        chk("t5_done_pre", 32'(done), 32'h0);
        core_done = 2'b11;
        step();
        core_done = 2'b00;
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_cs_end", 32'(core_start), 32'h0);
        chk("t5_id_hold", 32'(core_block_id), 32'h0100);

        // 6: asynchronous reset mid-DISPATCH, then a full rerun
        write_dcr(8'd10);
        pulse_start();
        step();
        step();
        chk("t6_cs_pre", 32'(core_start), 32'h3);
        #3 reset = 1'b0;
        #1;
        chk("t6_cs_async", 32'(core_start), 32'h0);
        chk("t6_busy_async", 32'(busy), 32'h0);
        chk("t6_done_async", 32'(done), 32'h0);
        step();
        reset = 1'b1;
        step();
        write_dcr(8'd10);
        pulse_start();
        step();
        chk("t6_cs_e1", 32'(core_start), 32'h1);
        chk("t6_id0_e1", 32'(bid(0)), 32'h0);
        step();
        chk("t6_id1_e2", 32'(bid(1)), 32'h1);
        chk("t6_tc1_e2", 32'(tcnt(1)), 32'h4);
        core_done = 2'b01;
        step();
        core_done = 2'b00;
        chk("t6_cs_retire", 32'(core_start), 32'h2);
        step();
        chk("t6_id0_blk2", 32'(bid(0)), 32'h2);
        chk("t6_tc0_blk2", 32'(tcnt(0)), 32'h2);
        chk("t6_done_mid", 32'(done), 32'h0);
        core_done = 2'b11;
        step();
        core_done = 2'b00;
        chk("t6_done", 32'(done), 32'h1);
        chk("t6_cs_end", 32'(core_start), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
